// File: rtl/mc_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_stall_ctrl_pkg
// Shared definitions for the pipeline stall controller: stall bus width and
// per-stage masks, multi-cycle op kind codes, sequencer state encoding and
// the stall-merge helper used to build the per-stage stall vector.
// ---------------------------------------------------------------------------
package mc_stall_ctrl_pkg;

    // Stall bus is {wb, mem, ex, id, if, pc}; bit 0 is pc.
    localparam int unsigned STALL_W = 6;

    // Bit position of the EX stall; used to decide when the sequencer re-arms.
    localparam int unsigned STALL_BIT_EX = 3;

    // Default watchdog settings; CNT_W must be wide enough to hold DIV_TIMEOUT.
    localparam int unsigned DIV_TIMEOUT_DEF = 64;
    localparam int unsigned CNT_W_DEF       = 7;

    // Per-stage stall masks. Each mask freezes its stage and everything upstream.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    // Multi-cycle op kind codes on mc_kind.
    localparam logic [1:0] MC_KIND_NONE = 2'b00;
    localparam logic [1:0] MC_KIND_MADD = 2'b01;
    localparam logic [1:0] MC_KIND_DIV  = 2'b10;
    localparam logic [1:0] MC_KIND_DIVU = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MADD2   = 2'd1,
        ST_DIV_RUN = 2'd2
    } state_e;

    // Merge stall requests. Masks are nested, so OR-ing them yields the
    // mask of the highest-priority active request.
    function automatic logic [STALL_W-1:0] stall_merge(
        input logic ex_req,
        input logic id_req,
        input logic if_req
    );
        logic [STALL_W-1:0] m;
        m = STALL_NONE;
        if (if_req) m = m | STALL_IF;
        if (id_req) m = m | STALL_ID;
        if (ex_req) m = m | STALL_EX;
        return m;
    endfunction

endpackage

// File: rtl/mc_stall_ctrl.sv
// ---------------------------------------------------------------------------
// mc_stall_ctrl
// Pipeline stall controller and multi-cycle execute sequencer for the 5-stage
// MIPS core. Merges IF/ID/EX stall requests into the per-stage stall vector,
// sequences two-cycle MADD/MSUB and the iterative divider (start/ready
// handshake with a watchdog), and handles pipeline flush.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   stallreq_if   in   fetch not ready
//   stallreq_id   in   load-use hazard from decode
//   stallreq_ex   in   generic execute stall (not sequenced)
//   mc_req        in   EX holds a multi-cycle op (level)
//   mc_kind[1:0]  in   00 none, 01 madd/msub, 10 div signed, 11 divu
//   flush         in   synchronous pipeline flush
//   div_ready_i   in   divider result valid pulse
//   div_start_o   out  divider start, high for the whole DIV_RUN
//   div_signed_o  out  registered signed-divide select
//   div_annul_o   out  one-cycle divider abort pulse
//   cnt_o[1:0]    out  MADD cycle index for EX
//   stall[5:0]    out  {wb,mem,ex,id,if,pc} stall vector (combinational)
//   busy_o        out  sequencer not idle
//   timeout_o     out  one-cycle watchdog abort pulse
// ---------------------------------------------------------------------------
module mc_stall_ctrl
    import mc_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               mc_req,
    input  logic [1:0]         mc_kind,
    input  logic               flush,
    input  logic               div_ready_i,
    output logic               div_start_o,
    output logic               div_signed_o,
    output logic               div_annul_o,
    output logic [1:0]         cnt_o,
    output logic [STALL_W-1:0] stall,
    output logic               busy_o,
    output logic               timeout_o
);

    // Last watchdog value before the divide is forcibly aborted.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wdog_q, wdog_d;
    logic                 div_signed_q, div_signed_d;
    logic                 arm_q, arm_d;

    logic                 seq_stall;
    logic                 annul_raw;
    logic                 timeout_raw;
    logic                 wdog_expired;
    logic [STALL_W-1:0]   stall_raw;

    // Sequencer next-state, watchdog and abort decisions.
    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        div_signed_d = div_signed_q;
        seq_stall    = 1'b0;
        annul_raw    = 1'b0;
        timeout_raw  = 1'b0;
        wdog_expired = (wdog_q == WDOG_LAST);

        unique case (state_q)
            ST_IDLE: begin
                // arm_q blocks re-entry on an op that EX has not yet released.
                if (mc_req && arm_q) begin
                    if (mc_kind == MC_KIND_MADD) begin
                        seq_stall = 1'b1;
                        state_d   = ST_MADD2;
                    end else if (mc_kind[1]) begin
                        seq_stall    = 1'b1;
                        state_d      = ST_DIV_RUN;
                        div_signed_d = ~mc_kind[0];
                        wdog_d       = '0;
                    end
                end
            end

            ST_MADD2: begin
                // Second MADD cycle: EX completes, no sequencer stall.
                state_d = ST_IDLE;
            end

            ST_DIV_RUN: begin
                if (div_ready_i) begin
                    // Release the stall so EX captures the quotient this cycle.
                    state_d = ST_IDLE;
                end else if (wdog_expired) begin
                    annul_raw   = 1'b1;
                    timeout_raw = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    seq_stall = 1'b1;
                    wdog_d    = wdog_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides everything; an in-flight divide is annulled even
        // if its result arrives in the same cycle.
        if (flush) begin
            state_d      = ST_IDLE;
            wdog_d       = '0;
            div_signed_d = div_signed_q;
            seq_stall    = 1'b0;
            timeout_raw  = 1'b0;
            annul_raw    = (state_q == ST_DIV_RUN);
        end
    end

    // Stall merge: flush > sequencer/EX > ID > IF.
    always_comb begin
        stall_raw = STALL_NONE;
        if (!flush) begin
            stall_raw = stall_merge(seq_stall | stallreq_ex, stallreq_id, stallreq_if);
        end
        // Re-arm only after a cycle in which EX was allowed to advance.
        arm_d = ~stall_raw[STALL_BIT_EX];
    end

    // State, watchdog, divide-sign and arm registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wdog_q       <= '0;
            div_signed_q <= 1'b0;
            arm_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            div_signed_q <= div_signed_d;
            arm_q        <= arm_d;
        end
    end

    // Combinational outputs are held quiet while reset is asserted.
    assign stall       = rst ? stall_raw   : STALL_NONE;
    assign div_annul_o = rst ? annul_raw   : 1'b0;
    assign timeout_o   = rst ? timeout_raw : 1'b0;

    // State-decoded outputs.
    assign busy_o       = (state_q != ST_IDLE);
    assign div_start_o  = (state_q == ST_DIV_RUN);
    assign cnt_o        = (state_q == ST_MADD2) ? 2'd1 : 2'd0;
    assign div_signed_o = div_signed_q;

endmodule

// File: tb/tb_mc_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_stall_ctrl
// Self-checking bench for mc_stall_ctrl. Each scenario task builds a list of
// per-cycle stimulus rows with hand-derived expected outputs; expectations are
// queued as stimulus is applied and popped when outputs are sampled.
// ---------------------------------------------------------------------------
module tb_mc_stall_ctrl;

    typedef struct packed {
        logic       r;
        logic       sif;
        logic       sid;
        logic       sex;
        logic       mreq;
        logic [1:0] kind;
        logic       fl;
        logic       rdy;
    } stim_t;

    // Sampled output bundle: stall, busy, start, signed, annul, cnt, timeout.
    typedef struct packed {
        logic [5:0] stall;
        logic       busy;
        logic       start;
        logic       sgn;
        logic       annul;
        logic [1:0] cnt;
        logic       tmo;
    } obs_t;

    typedef struct packed {
        stim_t s;
        obs_t  e;
    } row_t;

    localparam logic [5:0] S0  = 6'b000000;
    localparam logic [5:0] SIF = 6'b000011;
    localparam logic [5:0] SID = 6'b000111;
    localparam logic [5:0] SEX = 6'b001111;

    logic       clk;
    logic       rst;
    logic       stallreq_if;
    logic       stallreq_id;
    logic       stallreq_ex;
    logic       mc_req;
    logic [1:0] mc_kind;
    logic       flush;
    logic       div_ready_i;
    logic       div_start_o;
    logic       div_signed_o;
    logic       div_annul_o;
    logic [1:0] cnt_o;
    logic [5:0] stall;
    logic       busy_o;
    logic       timeout_o;

    obs_t exp_q[$];
    obs_t obs;
    int   n_checks;
    int   n_fail;
    logic sgn_exp;

    mc_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mc_req       (mc_req),
        .mc_kind      (mc_kind),
        .flush        (flush),
        .div_ready_i  (div_ready_i),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_annul_o  (div_annul_o),
        .cnt_o        (cnt_o),
        .stall        (stall),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic sif, input logic sid, input logic sex,
                                 input logic mreq, input logic [1:0] kind,
                                 input logic fl, input logic rdy);
        return {1'b1, sif, sid, sex, mreq, kind, fl, rdy};
    endfunction

    function automatic obs_t mk(input logic [5:0] s, input logic busy, input logic start,
                                input logic sgn, input logic annul, input logic [1:0] cnt,
                                input logic tmo);
        return {s, busy, start, sgn, annul, cnt, tmo};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, sample mid-cycle.
    task automatic apply(input stim_t s, input obs_t e);
        rst         = s.r;
        stallreq_if = s.sif;
        stallreq_id = s.sid;
        stallreq_ex = s.sex;
        mc_req      = s.mreq;
        mc_kind     = s.kind;
        flush       = s.fl;
        div_ready_i = s.rdy;
        exp_q.push_back(e);
        #4;
        obs = {stall, busy_o, div_start_o, div_signed_o, div_annul_o, cnt_o, timeout_o};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t  rows[$];
        stim_t s;
        obs_t  e;
        s = st(0, 0, 0, 0, 2'b00, 0, 0);
        s.r = 1'b0;
        rows.push_back({s, mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        obs_t e;
        rows.push_back({st(0, 1, 0, 0, 2'b00, 0, 0), mk(SID, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0,  0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(1, 1, 0, 0, 2'b00, 0, 0), mk(SID, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(1, 0, 0, 0, 2'b00, 0, 0), mk(SIF, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(1, 1, 0, 0, 2'b00, 1, 0), mk(S0,  0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(1, 1, 1, 0, 2'b00, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0,  0, 0, sgn_exp, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_use row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_madd();
        row_t rows[$];
        obs_t e;
        // Plain two-cycle MADD, then a drop of mc_req.
        rows.push_back({st(0, 0, 0, 1, 2'b01, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b01, 0, 0), mk(S0,  1, 0, sgn_exp, 0, 2'd1, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0,  0, 0, sgn_exp, 0, 2'd0, 0)});
        // EX held by a downstream stall in the second cycle: no re-entry after.
        rows.push_back({st(0, 0, 0, 1, 2'b01, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 1, 1, 2'b01, 0, 0), mk(SEX, 1, 0, sgn_exp, 0, 2'd1, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b01, 0, 0), mk(S0,  0, 0, sgn_exp, 0, 2'd0, 0)});
        // Kind 00 with mc_req is ignored.
        rows.push_back({st(0, 0, 0, 1, 2'b00, 0, 0), mk(S0,  0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0,  0, 0, sgn_exp, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL madd row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_div_signed();
        row_t rows[$];
        obs_t e;
        rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        for (int k = 1; k <= 34; k++)
            rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 0), mk(SEX, 1, 1, 1, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 1), mk(S0, 1, 1, 1, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 1, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL div_signed row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
        sgn_exp = 1'b1;
    endtask

    task automatic test_watchdog();
        row_t rows[$];
        obs_t e;
        rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        for (int k = 1; k <= 63; k++)
            rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(SEX, 1, 1, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(S0, 1, 1, 0, 1, 2'd0, 1)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL watchdog row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
        sgn_exp = 1'b0;
    endtask

    task automatic test_flush();
        row_t rows[$];
        obs_t e;
        // Flush at DIV_RUN cycle 10.
        rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        for (int k = 1; k <= 9; k++)
            rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 0), mk(SEX, 1, 1, 1, 0, 2'd0, 0)});
        rows.push_back({st(0, 1, 0, 1, 2'b10, 1, 0), mk(S0, 1, 1, 1, 1, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 1, 0, 2'd0, 0)});
        // Flush coinciding with div_ready_i is still annulled.
        rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(SEX, 0, 0, 1, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(SEX, 1, 1, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(SEX, 1, 1, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b11, 1, 1), mk(S0,  1, 1, 0, 1, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0,  0, 0, 0, 0, 2'd0, 0)});
        // Flush in MADD2 aborts silently.
        rows.push_back({st(0, 0, 0, 1, 2'b01, 0, 0), mk(SEX, 0, 0, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 1, 1, 2'b01, 1, 0), mk(S0,  1, 0, 0, 0, 2'd1, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0,  0, 0, 0, 0, 2'd0, 0)});
        // Flush in IDLE with a divide request prevents entry.
        rows.push_back({st(0, 0, 0, 1, 2'b10, 1, 0), mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL flush row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
        sgn_exp = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        row_t  rows[$];
        stim_t s;
        obs_t  e;
        rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        for (int k = 1; k <= 5; k++)
            rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 0), mk(SEX, 1, 1, 1, 0, 2'd0, 0)});
        // Reset asserted while the op is still presented: everything quiet at once.
        s = st(0, 0, 0, 1, 2'b10, 0, 0);
        s.r = 1'b0;
        rows.push_back({s, mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_div row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
        sgn_exp = 1'b0;
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        obs_t e;
        rows.push_back({st(0, 0, 0, 1, 2'b01, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b01, 0, 0), mk(S0,  1, 0, sgn_exp, 0, 2'd1, 0)});
        // Signed divide enters straight after MADD; result on first DIV_RUN cycle.
        rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 0), mk(SEX, 0, 0, sgn_exp, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b10, 0, 1), mk(S0,  1, 1, 1, 0, 2'd0, 0)});
        // Unsigned divide whose result lands on the last watchdog cycle.
        rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(SEX, 0, 0, 1, 0, 2'd0, 0)});
        for (int k = 1; k <= 63; k++)
            rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 0), mk(SEX, 1, 1, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 1, 2'b11, 0, 1), mk(S0, 1, 1, 0, 0, 2'd0, 0)});
        rows.push_back({st(0, 0, 0, 0, 2'b00, 0, 0), mk(S0, 0, 0, 0, 0, 2'd0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].e);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back row %0d: got %b want %b", i, obs, e);
            end
            tick();
        end
        sgn_exp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, want end before 200000 ns");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        sgn_exp     = 1'b0;
        rst         = 1'b0;
        stallreq_if = 1'b0;
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        mc_req      = 1'b0;
        mc_kind     = 2'b00;
        flush       = 1'b0;
        div_ready_i = 1'b0;
        tick();

        test_reset();
        test_load_use();
        test_madd();
        test_div_signed();
        test_watchdog();
        test_flush();
        test_reset_mid_div();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_stall_ctrl.md
Name: mc_stall_ctrl

Overview:
- Pipeline stall controller and multi-cycle execute sequencer for the 5-stage MIPS core.
- Merges stall requests from IF/ID/EX into the per-stage stall vector. Sequences two-cycle MADD/MSUB and the iterative divider through a start/ready handshake.
- Supports flush and a divide watchdog.
- Sits beside the pipeline registers; its stall vector drives pc_reg, if_id, id_ex, ex_mem and mem_wb.

Parameters:
DIV_TIMEOUT, 64, max cycles in DIV_RUN before forced abort
CNT_W, 7, width of watchdog counter (must hold DIV_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stallreq_if  in  1  fetch not ready
stallreq_id  in  1  load-use hazard from decode
stallreq_ex  in  1  generic execute stall (non-sequenced)
mc_req  in  1  EX stage holds a multi-cycle op (level, valid while op sits in EX)
mc_kind  in  2  00 none, 01 madd/msub, 10 div signed, 11 divu
flush  in  1  exception/branch-likely flush, synchronous
div_ready_i  in  1  divider result valid (one-cycle pulse)
div_start_o  out  1  divider start, held high during DIV_RUN
div_signed_o  out  1  1 = signed divide
div_annul_o  out  1  one-cycle pulse aborting divider
cnt_o  out  2  MADD cycle index to EX (0 first, 1 second)
stall  out  6  {wb,mem,ex,id,if,pc}; bit0 = pc
busy_o  out  1  state != IDLE
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst low, async): state IDLE, wdog=0, div_signed_o=0; all outputs 0.
- States: IDLE, MADD2, DIV_RUN.
- IDLE:
  - mc_req & mc_kind=01 -> MADD2; stall=6'b001111 this cycle; cnt_o=0.
  - mc_req & mc_kind[1] -> DIV_RUN; div_signed_o <= ~mc_kind[0] (registered); wdog<=0; stall=6'b001111.
  - mc_kind=00 with mc_req: ignored, no stall.
- MADD2: cnt_o=1; no sequencer stall; EX completes; -> IDLE unconditionally.
- DIV_RUN:
  - div_start_o=1.
  - !div_ready_i: stall=6'b001111; wdog increments.
  - div_ready_i: stall released this cycle so EX captures result; -> IDLE; div_start_o low next cycle.
  - Watchdog: wdog==DIV_TIMEOUT-1 and !div_ready_i -> div_annul_o=1, timeout_o=1, stall released, -> IDLE.
- Stall merge, combinational, same cycle as requests. Priority is flush > sequencer/stallreq_ex (001111) > stallreq_id (000111) > stallreq_if (000011) > 0. The OR of masks equals the highest-priority mask.
- Flush:
  - Forces stall=0 and state -> IDLE.
  - If state was DIV_RUN: div_annul_o=1 for that cycle.
  - A flush in the same cycle as div_ready_i is also annulled.
  - A flush in MADD2 aborts silently.
- No re-trigger: after returning to IDLE, the op that just completed has left EX. A stall from a downstream source holding EX must keep the FSM out of re-entry. The sequencer re-arms only on a cycle where stall[3]=0 was issued the previous cycle (registered arm flag, reset 1).
- div_signed_o is stable for the whole DIV_RUN.
- cnt_o=0 outside MADD2.
- Reset asserted mid-divide: returns to IDLE immediately with no annul pulse. The divider shares the same reset.

Decomposition:
- Shared package/defines: state encodings, mc_kind codes, stall masks (STALL_EX=6'b001111, STALL_ID=6'b000111, STALL_IF=6'b000011).
- Stall masks use the same defines file as the core (`StallBus` width 6).
- Single module; no sub-module needed. The watchdog counter is inline.

Test Plan:
- Reset: rst=0 then release, no requests -> stall=0, busy_o=0, div_start_o=0, cnt_o=0.
- Load-use: stallreq_id=1 for 1 cycle -> stall=6'b000111 that cycle only. Simultaneously with stallreq_if=1 -> still 000111.
- MADD: mc_req=1, kind=01 -> cycle0 stall=001111/cnt_o=0; cycle1 stall=0/cnt_o=1; cycle2 IDLE with no re-entry.
- DIV signed: mc_req, kind=10, div_ready_i at 35th DIV_RUN cycle -> div_start_o high 35 cycles, div_signed_o=1, stall=001111 until ready, released on the ready cycle.
- Watchdog: kind=11, never ready -> after 64 DIV_RUN cycles, div_annul_o=1, timeout_o=1, stall=0, busy_o=0 next cycle.
- Flush mid-divide: flush at cycle 10 of DIV_RUN -> stall=0, div_annul_o=1 that cycle, IDLE next. Async rst low mid-divide -> outputs 0 immediately.
